register_file_sequencer: RTL and testbench

Command-driven controller that owns every port of the 8×16-bit register file and sequences single operations on it: ALU op, load-immediate, register move, and a clear-all sweep. It sits between the instruction/command source and the register file plus the external combinational ALU. It accepts one command at a time over a valid/ready handshake and reports completion with a one-cycle `done` pulse.

---
 rtl/register_file_sequencer.sv | 126 ++++++++++++
 tb/tb_register_file_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sequencer.sv
// register_file_sequencer: runs one ALU / LOADI / MOVE / CLEAR_ALL command at a time on an 8x16 register file
// Ports: clk, reset (async, active high); cmd_valid/cmd_ready handshake with cmd_kind, cmd_alu_op,
// cmd_rd/rs1/rs2, cmd_imm; rf_read_*_addr/rf_read_bus_* read side; rf_write_addr/bus/enabled write side;
// alu_a/alu_b/alu_op to the external ALU with alu_result back; busy and one-cycle done status.
module register_file_sequencer #(
  parameter int ADDR_WIDTH = 3,
  parameter int REG_N      = 2**ADDR_WIDTH,
  parameter int REG_WIDTH  = 16,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_kind,
  input  logic [OP_WIDTH-1:0]   cmd_alu_op,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] cmd_rs2,
  input  logic [REG_WIDTH-1:0]  cmd_imm,
  output logic [ADDR_WIDTH-1:0] rf_read_1_addr,
  output logic [ADDR_WIDTH-1:0] rf_read_2_addr,
  input  logic [REG_WIDTH-1:0]  rf_read_bus_1,
  input  logic [REG_WIDTH-1:0]  rf_read_bus_2,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [REG_WIDTH-1:0]  rf_write_bus,
  output logic                  rf_write_enabled,
  output logic [REG_WIDTH-1:0]  alu_a,
  output logic [REG_WIDTH-1:0]  alu_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic [REG_WIDTH-1:0]  alu_result,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, CLEAR} state_t;
  state_t state;
  logic [1:0] kind;
  logic [OP_WIDTH-1:0] op;
  logic [ADDR_WIDTH-1:0] rd, cnt;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  // alu_a/alu_b double as the operand registers and rf_write_bus as the result register:
  // operands are only needed during EXEC and the result only during WRITE.
  // Read addresses are the latched rs1/rs2 and hold between commands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      kind <= '0;
      op <= '0;
      rd <= '0;
      cnt <= '0;
      rf_read_1_addr <= '0;
      rf_read_2_addr <= '0;
      rf_write_addr <= '0;
      rf_write_bus <= '0;
      rf_write_enabled <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          kind <= cmd_kind;
          op <= cmd_alu_op;
          rd <= cmd_rd;
          rf_read_1_addr <= cmd_rs1;
          rf_read_2_addr <= cmd_rs2;
          if (cmd_kind == 2'b01) begin
            state <= WRITE;
            rf_write_enabled <= 1'b1;
            rf_write_addr <= cmd_rd;
            rf_write_bus <= cmd_imm;
          end else if (cmd_kind == 2'b11) begin
            state <= CLEAR;
            cnt <= '0;
            rf_write_enabled <= 1'b1;
            rf_write_addr <= '0;
            rf_write_bus <= '0;
          end else begin
            state <= READ;
          end
        end
        READ: if (kind == 2'b00) begin
          state <= EXEC;
          alu_a <= rf_read_bus_1;
          alu_b <= rf_read_bus_2;
          alu_op <= op;
        end else begin
          state <= WRITE;
          rf_write_enabled <= 1'b1;
          rf_write_addr <= rd;
          rf_write_bus <= rf_read_bus_1;
        end
        EXEC: begin
          state <= WRITE;
          alu_a <= '0;
          alu_b <= '0;
          alu_op <= '0;
          rf_write_enabled <= 1'b1;
          rf_write_addr <= rd;
          rf_write_bus <= alu_result;
        end
        WRITE: begin
          state <= IDLE;
          rf_write_enabled <= 1'b0;
          rf_write_addr <= '0;
          rf_write_bus <= '0;
          done <= 1'b1;
        end
        CLEAR: if (cnt == ADDR_WIDTH'(REG_N - 1)) begin
          state <= IDLE;
          cnt <= '0;
          rf_write_enabled <= 1'b0;
          rf_write_addr <= '0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
          rf_write_addr <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_register_file_sequencer.sv
// tb_register_file_sequencer: directed bench with a register file and ALU model around register_file_sequencer
module tb_register_file_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_kind = '0;
  logic [2:0] cmd_alu_op = '0;
  logic [2:0] cmd_rd = '0;
  logic [2:0] cmd_rs1 = '0;
  logic [2:0] cmd_rs2 = '0;
  logic [15:0] cmd_imm = '0;
  logic [2:0] rf_read_1_addr, rf_read_2_addr, rf_write_addr;
  logic [15:0] rf_read_bus_1, rf_read_bus_2, rf_write_bus;
  logic rf_write_enabled;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic busy, done;
  logic [15:0] rf [8];
  int wr_count = 0;
  int errors = 0;
  int checks = 0;
  int n;
  always #5 clk = ~clk;
  register_file_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_alu_op(cmd_alu_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1),
    .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm), .rf_read_1_addr(rf_read_1_addr),
    .rf_read_2_addr(rf_read_2_addr), .rf_read_bus_1(rf_read_bus_1), .rf_read_bus_2(rf_read_bus_2),
    .rf_write_addr(rf_write_addr), .rf_write_bus(rf_write_bus), .rf_write_enabled(rf_write_enabled),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .done(done)
  );
  assign rf_read_bus_1 = rf[rf_read_1_addr];
  assign rf_read_bus_2 = rf[rf_read_2_addr];
  assign alu_result = alu_op == 3'd0 ? alu_a + alu_b : alu_op == 3'd1 ? alu_a - alu_b : alu_a ^ alu_b;
  always @(posedge clk) if (rf_write_enabled) begin
    rf[rf_write_addr] <= rf_write_bus;
    wr_count <= wr_count + 1;
  end
  task step;
    @(posedge clk);
    #1;
  endtask
  // Present a command for one edge, then scramble the fields to prove they were latched.
  task issue(input logic [1:0] k, input logic [2:0] op, input logic [2:0] rd,
             input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm);
    cmd_kind = k;
    cmd_alu_op = op;
    cmd_rd = rd;
    cmd_rs1 = rs1;
    cmd_rs2 = rs2;
    cmd_imm = imm;
    cmd_valid = 1'b1;
    step;
    cmd_valid = 1'b0;
    cmd_kind = ~k;
    cmd_alu_op = ~op;
    cmd_rd = ~rd;
    cmd_rs1 = ~rs1;
    cmd_rs2 = ~rs2;
    cmd_imm = ~imm;
  endtask
  task loadi(input logic [2:0] rd, input logic [15:0] imm);
    issue(2'b01, 3'd0, rd, 3'd0, 3'd0, imm);
    step;
  endtask
  task test_reset;
    cmd_kind = 2'b01;
    cmd_rd = 3'd5;
    cmd_imm = 16'h0001;
    cmd_valid = 1'b1;
    step;
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (rf_write_enabled !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_write_enabled); end
    checks++; if ({rf_write_addr, rf_write_bus, rf_read_1_addr, rf_read_2_addr} !== 25'd0) begin errors++; $display("FAIL reset_rf_outs: got %h want 0", {rf_write_addr, rf_write_bus, rf_read_1_addr, rf_read_2_addr}); end
    checks++; if ({alu_a, alu_b, alu_op} !== 35'd0) begin errors++; $display("FAIL reset_alu_outs: got %h want 0", {alu_a, alu_b, alu_op}); end
    cmd_valid = 1'b0;
    reset = 1'b0;
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_accept: busy got %b want 0", busy); end
  endtask
  task test_loadi;
    issue(2'b01, 3'd0, 3'd5, 3'd0, 3'd0, 16'hBEEF);
    checks++; if (rf_write_enabled !== 1'b1) begin errors++; $display("FAIL loadi_we: got %b want 1", rf_write_enabled); end
    checks++; if (rf_write_addr !== 3'd5) begin errors++; $display("FAIL loadi_addr: got %0d want 5", rf_write_addr); end
    checks++; if (rf_write_bus !== 16'hBEEF) begin errors++; $display("FAIL loadi_data: got %h want beef", rf_write_bus); end
    checks++; if ({cmd_ready, busy, done} !== 3'b010) begin errors++; $display("FAIL loadi_c1_status: got %b want 010", {cmd_ready, busy, done}); end
    step;
    checks++; if ({done, cmd_ready, rf_write_enabled} !== 3'b110) begin errors++; $display("FAIL loadi_c2_status: got %b want 110", {done, cmd_ready, rf_write_enabled}); end
    checks++; if (rf[5] !== 16'hBEEF) begin errors++; $display("FAIL loadi_r5: got %h want beef", rf[5]); end
    step;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL loadi_done_width: got %b want 0", done); end
  endtask
  task test_alu;
    loadi(3'd1, 16'h0003);
    loadi(3'd2, 16'h0004);
    issue(2'b00, 3'd0, 3'd3, 3'd1, 3'd2, 16'h0);
    checks++; if ({rf_read_1_addr, rf_read_2_addr} !== 6'o12) begin errors++; $display("FAIL alu_c1_raddr: got %o want 12", {rf_read_1_addr, rf_read_2_addr}); end
    checks++; if ({rf_write_enabled, alu_a} !== 17'd0) begin errors++; $display("FAIL alu_c1_idle: got %h want 0", {rf_write_enabled, alu_a}); end
    step;
    checks++; if ({alu_a, alu_b} !== {16'h0003, 16'h0004}) begin errors++; $display("FAIL alu_c2_operands: got %h want 00030004", {alu_a, alu_b}); end
    checks++; if ({alu_op, rf_write_enabled} !== 4'b0000) begin errors++; $display("FAIL alu_c2_op_we: got %b want 0000", {alu_op, rf_write_enabled}); end
    step;
    checks++; if ({rf_write_enabled, rf_write_addr, rf_write_bus} !== {1'b1, 3'd3, 16'h0007}) begin errors++; $display("FAIL alu_c3_write: got %h want b0007", {rf_write_enabled, rf_write_addr, rf_write_bus}); end
    checks++; if ({done, alu_a, alu_b} !== 33'd0) begin errors++; $display("FAIL alu_c3_idle: got %h want 0", {done, alu_a, alu_b}); end
    step;
    checks++; if ({done, rf_write_enabled} !== 2'b10) begin errors++; $display("FAIL alu_c4_done: got %b want 10", {done, rf_write_enabled}); end
    checks++; if (rf[3] !== 16'h0007) begin errors++; $display("FAIL alu_r3: got %h want 0007", rf[3]); end
  endtask
  task test_alias_move;
    loadi(3'd1, 16'h0010);
    issue(2'b00, 3'd0, 3'd1, 3'd1, 3'd1, 16'h0);
    step;
    step;
    step;
    checks++; if ({done, rf[1]} !== {1'b1, 16'h0020}) begin errors++; $display("FAIL alias_r1: got %h want 10020", {done, rf[1]}); end
    issue(2'b10, 3'd0, 3'd6, 3'd1, 3'd0, 16'h0);
    checks++; if ({rf_read_1_addr, rf_write_enabled} !== 4'b0010) begin errors++; $display("FAIL move_c1: got %b want 0010", {rf_read_1_addr, rf_write_enabled}); end
    step;
    checks++; if ({rf_write_enabled, rf_write_addr, rf_write_bus} !== {1'b1, 3'd6, 16'h0020}) begin errors++; $display("FAIL move_c2_write: got %h want e0020", {rf_write_enabled, rf_write_addr, rf_write_bus}); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL move_c2_done: got %b want 0", done); end
    step;
    checks++; if ({done, rf[6]} !== {1'b1, 16'h0020}) begin errors++; $display("FAIL move_c3_r6: got %h want 10020", {done, rf[6]}); end
  endtask
  task test_clear;
    logic any;
    for (int i = 0; i < 8; i++) loadi(3'(i), 16'h1000 + 16'(i));
    n = wr_count;
    issue(2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      checks++; if ({rf_write_enabled, rf_write_addr, rf_write_bus} !== {1'b1, 3'(i), 16'h0}) begin errors++; $display("FAIL clear_c%0d_write: got %h want %h", i + 1, {rf_write_enabled, rf_write_addr, rf_write_bus}, {1'b1, 3'(i), 16'h0}); end
      checks++; if ({cmd_ready, done} !== 2'b00) begin errors++; $display("FAIL clear_c%0d_status: got %b want 00", i + 1, {cmd_ready, done}); end
      step;
    end
    checks++; if ({done, cmd_ready, rf_write_enabled} !== 3'b110) begin errors++; $display("FAIL clear_c9_status: got %b want 110", {done, cmd_ready, rf_write_enabled}); end
    checks++; if (wr_count - n !== 8) begin errors++; $display("FAIL clear_write_count: got %0d want 8", wr_count - n); end
    any = 1'b0;
    for (int i = 0; i < 8; i++) any = any | (rf[i] !== 16'h0);
    checks++; if (any !== 1'b0) begin errors++; $display("FAIL clear_regs_zero: got nonzero=%b want 0", any); end
    step;
    checks++; if ({done, rf_write_enabled, busy} !== 3'b000) begin errors++; $display("FAIL clear_no_second_pass: got %b want 000", {done, rf_write_enabled, busy}); end
  endtask
  task test_back_to_back;
    loadi(3'd6, 16'h0020);
    loadi(3'd7, 16'h0005);
    n = wr_count;
    issue(2'b00, 3'd1, 3'd4, 3'd6, 3'd7, 16'h0);
    cmd_kind = 2'b01;
    cmd_rd = 3'd0;
    cmd_imm = 16'h1234;
    cmd_valid = 1'b1;
    step;
    checks++; if ({alu_op, alu_a, alu_b} !== {3'd1, 16'h0020, 16'h0005}) begin errors++; $display("FAIL b2b_c2_alu: got %h want %h", {alu_op, alu_a, alu_b}, {3'd1, 16'h0020, 16'h0005}); end
    cmd_valid = 1'b0;
    cmd_kind = 2'b11;
    step;
    cmd_valid = 1'b1;
    checks++; if ({rf_write_addr, rf_write_bus} !== {3'd4, 16'h001B}) begin errors++; $display("FAIL b2b_c3_write: got %h want 4001b", {rf_write_addr, rf_write_bus}); end
    cmd_kind = 2'b01;
    cmd_rd = 3'd2;
    cmd_imm = 16'hA5A5;
    step;
    checks++; if ({done, cmd_ready, busy} !== 3'b110) begin errors++; $display("FAIL b2b_c4_status: got %b want 110", {done, cmd_ready, busy}); end
    checks++; if (wr_count - n !== 1 || rf[0] !== 16'h0 || rf[4] !== 16'h001B) begin errors++; $display("FAIL b2b_ignored_cmds: writes %0d r0 %h r4 %h want 1 0000 001b", wr_count - n, rf[0], rf[4]); end
    step;
    cmd_valid = 1'b0;
    checks++; if ({rf_write_enabled, rf_write_addr, rf_write_bus} !== {1'b1, 3'd2, 16'hA5A5}) begin errors++; $display("FAIL b2b_loadi_write: got %h want 2a5a5 with we", {rf_write_enabled, rf_write_addr, rf_write_bus}); end
    step;
    checks++; if ({done, rf[2]} !== {1'b1, 16'hA5A5}) begin errors++; $display("FAIL b2b_loadi_done: got %h want 1a5a5", {done, rf[2]}); end
    checks++; if (wr_count - n !== 2) begin errors++; $display("FAIL b2b_write_count: got %0d want 2", wr_count - n); end
  endtask
  task test_reset_mid_clear;
    for (int i = 0; i < 8; i++) loadi(3'(i), 16'h0100 + 16'(i));
    n = wr_count;
    issue(2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    step;
    step;
    step;
    checks++; if ({rf_write_enabled, rf_write_addr} !== 4'b1011) begin errors++; $display("FAIL rclr_c4_addr: got %b want 1011", {rf_write_enabled, rf_write_addr}); end
    reset = 1'b1;
    #1;
    checks++; if ({rf_write_enabled, busy, cmd_ready} !== 3'b001) begin errors++; $display("FAIL rclr_async: got %b want 001", {rf_write_enabled, busy, cmd_ready}); end
    step;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rclr_done_1: got %b want 0", done); end
    step;
    reset = 1'b0;
    step;
    checks++; if ({done, busy, rf_write_enabled} !== 3'b000) begin errors++; $display("FAIL rclr_after: got %b want 000", {done, busy, rf_write_enabled}); end
    checks++; if (wr_count - n !== 3) begin errors++; $display("FAIL rclr_write_count: got %0d want 3", wr_count - n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rf[i] !== (i < 3 ? 16'h0 : 16'h0100 + 16'(i))) begin errors++; $display("FAIL rclr_r%0d: got %h want %h", i, rf[i], i < 3 ? 16'h0 : 16'h0100 + 16'(i)); end
    end
  endtask
  initial begin
    test_reset;
    test_loadi;
    test_alu;
    test_alias_move;
    test_clear;
    test_back_to_back;
    test_reset_mid_clear;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
